// File: rtl/prbs_burst_ctrl.sv
// rtl/prbs_burst_ctrl.sv - PRBS31 burst sequencer: preamble framing, repeated bursts, single-bit error injection
module prbs_burst_ctrl #(
  parameter int LEN_W   = 16,
  parameter int PRE_LEN = 8,
  parameter int GAP_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [3:0]       burst_cnt,
  input  logic             inj_en,
  input  logic [LEN_W-1:0] inj_idx,
  input  logic             lfsr_bit,
  output logic             lfsr_load,
  output logic             lfsr_en,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             tx_sof,
  output logic             busy,
  output logic             done,
  output logic [3:0]       burst_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRE, S_RUN, S_GAP, S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] PRE_LAST = LEN_W'(PRE_LEN - 1);
  localparam logic [LEN_W-1:0] GAP_LAST = LEN_W'(GAP_LEN - 1);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bidx_q, bidx_d;
  logic [LEN_W-1:0] len_s_q, len_s_d;
  logic [3:0]       bcnt_s_q, bcnt_s_d;
  logic             inj_en_s_q, inj_en_s_d;
  logic [LEN_W-1:0] inj_idx_s_q, inj_idx_s_d;
  logic             last_burst;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bidx_q      <= '0;
      len_s_q     <= '0;
      bcnt_s_q    <= '0;
      inj_en_s_q  <= 1'b0;
      inj_idx_s_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bidx_q      <= bidx_d;
      len_s_q     <= len_s_d;
      bcnt_s_q    <= bcnt_s_d;
      inj_en_s_q  <= inj_en_s_d;
      inj_idx_s_q <= inj_idx_s_d;
    end
  end

  // Captured burst count is never zero, so the subtraction cannot wrap.
  assign last_burst = (bidx_q == bcnt_s_q - 4'd1);
  assign burst_idx  = bidx_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bidx_d      = bidx_q;
    len_s_d     = len_s_q;
    bcnt_s_d    = bcnt_s_q;
    inj_en_s_d  = inj_en_s_q;
    inj_idx_s_d = inj_idx_s_q;
    lfsr_load   = 1'b0;
    lfsr_en     = 1'b0;
    tx_bit      = 1'b0;
    tx_valid    = 1'b0;
    tx_sof      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          len_s_d     = burst_len;
          bcnt_s_d    = (burst_cnt == 4'd0) ? 4'd1 : burst_cnt;
          inj_en_s_d  = inj_en;
          inj_idx_s_d = inj_idx;
          cnt_d       = '0;
          bidx_d      = '0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        busy      = 1'b1;
        lfsr_load = 1'b1;
        cnt_d     = '0;
        state_d   = S_PRE;
      end
      S_PRE: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_bit   = ~cnt_q[0];
        tx_sof   = (cnt_q == '0);
        if (cnt_q == PRE_LAST) begin
          cnt_d = '0;
          if (len_s_q != '0)  state_d = S_RUN;
          else if (last_burst) state_d = S_DONE;
          else                 state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        lfsr_en  = 1'b1;
        // Indices at or beyond the burst length never match, so they inject nothing.
        tx_bit   = lfsr_bit ^ (inj_en_s_q && (cnt_q == inj_idx_s_q));
        if (cnt_q == len_s_q - ONE) begin
          cnt_d   = '0;
          state_d = last_burst ? S_DONE : S_GAP;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          bidx_d  = bidx_q + 4'd1;
          state_d = S_PRE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        bidx_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      bidx_d  = '0;
    end
  end

endmodule

// File: doc/prbs_burst_ctrl.md
Name: prbs_burst_ctrl

Overview:
Sequencer for the PRBS31 generator datapath (external LFSR, taps 27/30, output = bit 30, seed 31'h1).
- Accepts a burst command and drives LFSR load/advance.
- Frames each burst with a fixed 1010 preamble, repeats bursts with idle gaps, and can inject a single-bit error at a chosen bit index.
- Sits between the pin-level command inputs and the LFSR.
- Provides a framed serial test stream (tx_bit/tx_valid/tx_sof) plus busy/done status.

Parameters:
- LEN_W, 16, width of burst length and injection index.
- PRE_LEN, 8, preamble bits per burst (>=1).
- GAP_LEN, 4, idle cycles between consecutive bursts (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-high (1 = reset)
- start  in  1  command strobe, sampled in IDLE only
- abort  in  1  terminate any active sequence
- burst_len  in  LEN_W  PRBS bits per burst
- burst_cnt  in  4  number of bursts; 0 treated as 1
- inj_en  in  1  enable error injection
- inj_idx  in  LEN_W  RUN-bit index (0-based) to invert, in every burst
- lfsr_bit  in  1  current LFSR output bit (lfsr[30]), combinational from datapath
- lfsr_load  out  1  one-cycle pulse: datapath reloads seed 31'h1
- lfsr_en  out  1  datapath shifts one step at this clock edge
- tx_bit  out  1  serial stream bit
- tx_valid  out  1  tx_bit meaningful
- tx_sof  out  1  first preamble bit of each burst
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on normal completion
- burst_idx  out  4  0-based index of current burst

Behaviour:
- States: IDLE, LOAD, PRE, RUN, GAP, DONE. Single counter cnt (LEN_W bits) for PRE/RUN/GAP; separate 4-bit burst counter.
- Reset (rst_n=1 at edge): state IDLE, cnt=0, burst_idx=0, all shadow regs 0. All outputs 0 while in IDLE.
- IDLE: start=1 and abort=0 -> capture burst_len, burst_cnt (0->1), inj_en, inj_idx into shadow regs; go to LOAD. Inputs are ignored afterward until IDLE.
- LOAD (1 cycle): lfsr_load=1, tx_valid=0 -> PRE, cnt=0.
- PRE (PRE_LEN cycles):
  - tx_valid=1; tx_bit = ~cnt[0] (1,0,1,0...); tx_sof=1 only at cnt=0; lfsr_en=0.
  - At cnt=PRE_LEN-1 -> RUN, cnt=0; if shadow burst_len=0 -> skip RUN (go to GAP or DONE directly).
- RUN (burst_len cycles):
  - tx_valid=1; lfsr_en=1; tx_bit = lfsr_bit ^ (inj_en_s && cnt==inj_idx_s).
  - inj_idx >= burst_len: no injection.
  - At cnt=burst_len-1: if burst_idx == burst_cnt_s-1 -> DONE, else -> GAP with cnt=0.
- GAP (GAP_LEN cycles): tx_valid=0, lfsr_en=0, LFSR not reloaded (sequence continues across bursts). At end: burst_idx+1, -> PRE, cnt=0.
- DONE (1 cycle): done=1, busy=1 -> IDLE, burst_idx=0.
- abort=1 in any non-IDLE state -> IDLE next edge.
  - No done pulse.
  - tx_valid, lfsr_en, lfsr_load low from that edge.
  - abort beats start; abort in IDLE has no effect.
- start outside IDLE is ignored (no queuing); start in DONE is ignored.
- Reset mid-sequence behaves as abort, plus shadow regs cleared.
- Counter compares are exact equality at full LEN_W width; burst_len up to 2^LEN_W-1.
- Timing: start sampled at edge 0 -> LOAD during cycle 1 -> first preamble bit in cycle 2 -> first RUN bit in cycle 2+PRE_LEN.
- All state is registered; tx_bit in RUN is the only combinational path from an input (lfsr_bit).

Test Plan:
- Reset, then start with burst_len=32, burst_cnt=1, inj_en=0:
  - lfsr_load pulses in cycle 1; preamble 10101010 with tx_sof on first bit.
  - RUN bits 0..29 = 0, bit 30 = 1, lfsr_en high exactly 32 cycles.
  - done pulses once; busy falls next cycle.
- Same command with inj_en=1, inj_idx=5 -> RUN bit 5 = 1, all other bits identical to the previous run; inj_idx=40 -> stream unchanged.
- burst_cnt=3, burst_len=16:
  - Three preamble+RUN frames separated by 4 tx_valid=0 cycles; burst_idx 0,1,2; lfsr_load once.
  - RUN bits concatenate to the first 48 PRBS31 bits.
- abort asserted on RUN bit 10 -> IDLE next cycle, no done, tx_valid=0; subsequent start reloads the seed and restarts from bit 0.
- start held high through an entire sequence -> one sequence per IDLE visit only; start together with abort in IDLE -> stays IDLE.
- burst_cnt=0, burst_len=0 -> LOAD, 8-bit preamble, DONE; lfsr_en never asserted; done pulses.
